// File: rtl/sync_tp_ram_reader.sv
// ---------------------------------------------------------------------------
// sync_tp_ram_reader
//
// Streaming read controller for the read port of a synchronous two-port RAM.
// It accepts a burst command (start address, word count) and issues one RAM
// read per cycle, wrapping the address from DATA_DEPTH-1 back to 0. It absorbs
// the fixed RAM read latency and presents the words as a valid/ready stream
// with a last-word marker.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload until that edge. A sink may
// drop or raise ready at any time. This applies to Cmd* and to Out*.
//
// Ports
//   Clk_CI        clock, rising edge
//   Rst_RBI       asynchronous reset, active low
//   CmdValid_SI   burst command valid
//   CmdReady_SO   command ready (high only in IDLE)
//   CmdAddr_DI    start address (must be < DATA_DEPTH)
//   CmdLen_DI     word count, 0 allowed
//   RamRdEn_SO    RAM read enable (registered)
//   RamRdAddr_DO  RAM read address (registered)
//   RamRdData_DI  RAM read data, valid RAM_LAT cycles after the enable
//   OutValid_SO   output word valid
//   OutReady_SI   consumer ready
//   OutData_DO    output word
//   OutLast_SO    final word of the burst
//   Busy_SO       burst in progress
//   Done_SO       one-cycle pulse after the burst completes
//   State_DO      current FSM state (IDLE=0, ISSUE=1, DRAIN=2), for debug
// ---------------------------------------------------------------------------
module sync_tp_ram_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_LAT    = 1,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  CmdValid_SI,
    output logic                  CmdReady_SO,
    input  logic [ADDR_WIDTH-1:0] CmdAddr_DI,
    input  logic [LEN_WIDTH-1:0]  CmdLen_DI,
    output logic                  RamRdEn_SO,
    output logic [ADDR_WIDTH-1:0] RamRdAddr_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData_DI,
    output logic                  OutValid_SO,
    input  logic                  OutReady_SI,
    output logic [DATA_WIDTH-1:0] OutData_DO,
    output logic                  OutLast_SO,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic [1:0]            State_DO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FD         = RAM_LAT + 2;         // output FIFO depth
    localparam int PW         = $clog2(FD);
    localparam int FIFO_SLOTS = 1 << PW;
    localparam int CW         = $clog2(FD + 1) + 1;  // counter width with headroom
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;         // next address to read
    logic [LEN_WIDTH-1:0]    r_remaining;    // reads still to issue
    logic                    r_rd_en;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_rd_last;
    logic [RAM_LAT-1:0]      r_sr_vld;       // tracks reads through the RAM latency
    logic [RAM_LAT-1:0]      r_sr_last;
    logic [DATA_WIDTH-1:0]   r_fifo_data [0:FIFO_SLOTS-1];
    logic                    r_fifo_last [0:FIFO_SLOTS-1];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_fifo_cnt;
    logic                    r_done;

    logic                    w_cmd_fire;
    logic                    w_cmd_zero;
    logic                    w_out_valid;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_head_last;
    logic [CW-1:0]           w_inflight;
    logic [CW-1:0]           w_credit;
    logic                    w_issue;
    logic                    w_done_next;

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_cmd_fire  = CmdValid_SI && (r_state == IDLE);
    assign w_cmd_zero  = w_cmd_fire && (CmdLen_DI == '0);
    assign w_out_valid = (r_fifo_cnt != '0);
    assign w_pop       = w_out_valid && OutReady_SI;
    assign w_push      = r_sr_vld[RAM_LAT-1];
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Credit = reads enabled or in the RAM pipe + words buffered, less the
    // word leaving this cycle. The pop term only reaches the D input of the
    // read-enable flop, so OutReady_SI never combinationally drives the RAM
    // port, yet a free-flowing consumer keeps the issue rate at 1 word/cycle.
    always_comb begin
        w_inflight = CW'(r_rd_en);
        for (int i = 0; i < RAM_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_sr_vld[i]);
        end
        w_credit = w_inflight + r_fifo_cnt - CW'(w_pop);
    end

    assign w_issue = (r_state == ISSUE) && (r_remaining != '0) && (w_credit < CW'(FD));

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    if (w_cmd_zero) begin
                        w_done_next = 1'b1;
                    end else if (CmdLen_DI == LEN_ONE) begin
                        w_state_next = DRAIN;  // the only read goes out at the handshake
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (w_issue && (r_remaining == LEN_ONE)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Read issue. The first read is launched straight from the handshake so
    // RamRdEn_SO rises the cycle after the command is accepted.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_last   <= 1'b0;
        end else if (w_cmd_fire && !w_cmd_zero) begin
            r_rd_en     <= 1'b1;
            r_rd_addr   <= CmdAddr_DI;
            r_rd_last   <= (CmdLen_DI == LEN_ONE);
            r_addr      <= f_next_addr(CmdAddr_DI);
            r_remaining <= CmdLen_DI - LEN_ONE;
        end else if (w_issue) begin
            r_rd_en     <= 1'b1;
            r_rd_addr   <= r_addr;
            r_rd_last   <= (r_remaining == LEN_ONE);
            r_addr      <= f_next_addr(r_addr);
            r_remaining <= r_remaining - LEN_ONE;
        end else begin
            r_rd_en     <= 1'b0;
            r_rd_last   <= 1'b0;
        end
    end

    // Latency tracking: the bit leaving the top marks RamRdData_DI as valid.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_sr_vld  <= '0;
            r_sr_last <= '0;
        end else begin
            r_sr_vld[0]  <= r_rd_en;
            r_sr_last[0] <= r_rd_last;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
            end
        end
    end

    // FIFO storage needs no reset: the outputs are gated by the occupancy.
    always_ff @(posedge Clk_CI) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= RamRdData_DI;
            r_fifo_last[r_wr_ptr] <= r_sr_last[RAM_LAT-1];
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign CmdReady_SO  = (r_state == IDLE);
    assign Busy_SO      = (r_state != IDLE);
    assign Done_SO      = r_done;
    assign State_DO     = r_state;
    assign RamRdEn_SO   = r_rd_en;
    assign RamRdAddr_DO = r_rd_addr;
    assign OutValid_SO  = w_out_valid;
    assign OutData_DO   = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign OutLast_SO   = w_out_valid && w_head_last;

    // A start address beyond the RAM is a caller error.
    a_cmd_addr_in_range: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
        (CmdValid_SI && CmdReady_SO) |-> ({1'b0, CmdAddr_DI} < DEPTH_W));

endmodule
